// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch buffer feeding {pc, instr, pc+4} to IF/ID.
// Latency: request accepted in cycle t, response in t+L, head entry valid from t+L+1 (outputs come from flops).
// Backpressure: no new request once allocated + to-be-discarded entries reach DEPTH; out_ready low holds the head.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   redirect_valid, redirect_pc     taken branch/jump from EX: flush and restart at target
//   imem_req_valid/addr/ready       fetch request handshake, address word aligned
//   imem_rsp_valid/data             in-order response, one per accepted request
//   out_valid/pc/instr/pcplus4      head entry towards IF/ID, popped with out_ready
//   dbg_count                       number of allocated entries
//   err_unexpected_rsp              sticky: a response arrived with nothing waiting for it
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_pcplus4,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] dbg_count,
  output logic                       err_unexpected_rsp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t            PTR_ONE   = ptr_t'(1);
  localparam cnt_t            CNT_ONE   = cnt_t'(1);
  localparam logic [CNT_W:0]  EXT_ONE   = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]  DEPTH_EXT = (CNT_W+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [XLEN-1:0]  pc_d    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  ptr_t             head_q, head_d;
  ptr_t             fill_q, fill_d;
  ptr_t             tail_q, tail_d;
  cnt_t             count_q, count_d;
  // Allocated entries still waiting for their response (tail - fill, without wrap ambiguity).
  cnt_t             pend_q, pend_d;
  cnt_t             drop_cnt_q, drop_cnt_d;
  logic             err_q, err_d;

  logic [CNT_W:0]   slots_used;
  logic [CNT_W:0]   redirect_drop;
  logic [CNT_W:0]   redirect_drop_less;
  logic             req_fire;
  logic             pop;
  logic             rsp_fill;
  logic             redirect_pc_unused;

  // Target low bits are forced to zero, so they are deliberately ignored.
  assign redirect_pc_unused = ^redirect_pc[1:0];

  // Credit check uses registered occupancy only: a pop this cycle frees a slot next cycle.
  assign slots_used     = {1'b0, count_q} + {1'b0, drop_cnt_q};
  assign imem_req_valid = ~redirect_valid & (slots_used < DEPTH_EXT);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign out_valid   = (count_q != '0) & filled_q[head_q];
  assign out_pc      = pc_q[head_q];
  assign out_instr   = instr_q[head_q];
  assign out_pcplus4 = pc_q[head_q] + PC_STEP;
  assign pop         = out_valid & out_ready;

  assign rsp_fill = imem_rsp_valid & ~redirect_valid & (drop_cnt_q == '0) & (pend_q != '0);

  // On redirect every unanswered request becomes a response to throw away,
  // less the one arriving in the redirect cycle itself.
  assign redirect_drop      = {1'b0, drop_cnt_q} + {1'b0, pend_q};
  assign redirect_drop_less = redirect_drop - EXT_ONE;

  assign dbg_count          = count_q;
  assign err_unexpected_rsp = err_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    filled_d   = filled_q;
    head_d     = head_q;
    fill_d     = fill_q;
    tail_d     = tail_q;
    count_d    = count_q;
    pend_d     = pend_q;
    drop_cnt_d = drop_cnt_q;
    err_d      = err_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      filled_d   = '0;
      head_d     = tail_q;
      fill_d     = tail_q;
      count_d    = '0;
      pend_d     = '0;
      if (imem_rsp_valid) begin
        if (redirect_drop == '0) begin
          err_d      = 1'b1;
          drop_cnt_d = '0;
        end else begin
          drop_cnt_d = redirect_drop_less[CNT_W-1:0];
        end
      end else begin
        drop_cnt_d = redirect_drop[CNT_W-1:0];
      end
    end else begin
      if (imem_rsp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CNT_ONE;
        end else if (pend_q != '0) begin
          instr_d[fill_q]  = imem_rsp_data;
          filled_d[fill_q] = 1'b1;
          fill_d           = fill_q + PTR_ONE;
        end else begin
          err_d = 1'b1;
        end
      end

      // tail never equals fill while a fill is possible and a slot is free,
      // so these writes cannot collide with the fill above.
      if (req_fire) begin
        pc_d[tail_q]     = fetch_pc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PTR_ONE;
        fetch_pc_d       = fetch_pc_q + PC_STEP;
      end

      if (pop) begin
        head_d = head_q + PTR_ONE;
      end

      unique case ({req_fire, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      unique case ({req_fire, rsp_fill})
        2'b10:   pend_d = pend_q + CNT_ONE;
        2'b01:   pend_d = pend_q - CNT_ONE;
        default: pend_d = pend_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      filled_q   <= '0;
      head_q     <= '0;
      fill_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      filled_q   <= filled_d;
      head_q     <= head_d;
      fill_q     <= fill_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: drives fetch_queue with an in-order memory of configurable latency
// and compares against a queue-based model of the fetch stream.
module tb_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            reset;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pcplus4;
  logic            out_ready;
  logic [CW-1:0]   dbg_count;
  logic            err_unexpected_rsp;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_pcplus4(out_pcplus4),
    .out_ready(out_ready), .dbg_count(dbg_count), .err_unexpected_rsp(err_unexpected_rsp)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  ent_t  mbuf[$];   // model: allocated entries, oldest first
  mreq_t mq[$];     // memory: accepted requests awaiting response
  logic [31:0] m_fpc;
  int          m_drop;
  bit          m_err;

  int checks = 0, failures = 0;
  int cyc = 0, lat = 1, jit_max = 0;
  bit inj_v = 0;
  logic [31:0] inj_d = '0;

  logic          exp_req_valid, exp_out_valid, exp_err;
  logic [31:0]   exp_req_addr, exp_out_pc, exp_out_instr;
  logic [CW-1:0] exp_count;
  logic          s_dut_req;
  logic [31:0]   s_dut_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 | a;
  endfunction

  // Present the memory response for this cycle and compute model expectations.
  task automatic drive();
    if (inj_v) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = inj_d;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    end
    #1;
    exp_req_valid = !redirect_valid && (mbuf.size() + m_drop < DEPTH);
    exp_req_addr  = m_fpc;
    exp_out_valid = mbuf.size() > 0 && mbuf[0].filled;
    exp_out_pc    = '0;
    exp_out_instr = '0;
    if (mbuf.size() > 0) begin
      exp_out_pc    = mbuf[0].pc;
      exp_out_instr = mbuf[0].instr;
    end
    exp_count  = CW'(mbuf.size());
    exp_err    = m_err;
    s_dut_req  = imem_req_valid;
    s_dut_addr = imem_req_addr;
  endtask

  // Clock edge: advance model and memory with the inputs that were applied.
  task automatic tick();
    bit rsp, pop;
    logic [31:0] rd;
    int unf, nd, idx;
    rsp = imem_rsp_valid;
    rd  = imem_rsp_data;
    @(posedge clk);
    if (reset) begin
      mbuf.delete(); mq.delete();
      m_drop = 0; m_err = 0; m_fpc = 32'h0;
    end else begin
      if (redirect_valid) begin
        unf = 0;
        foreach (mbuf[i]) if (!mbuf[i].filled) unf++;
        nd = m_drop + unf - (rsp ? 1 : 0);
        if (nd < 0) begin nd = 0; m_err = 1; end
        m_drop = nd;
        mbuf.delete();
        m_fpc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        pop = mbuf.size() > 0 && mbuf[0].filled && out_ready;
        if (rsp) begin
          if (m_drop > 0) m_drop--;
          else begin
            idx = -1;
            for (int i = 0; i < mbuf.size(); i++)
              if (!mbuf[i].filled) begin idx = i; break; end
            if (idx >= 0) begin mbuf[idx].instr = rd; mbuf[idx].filled = 1; end
            else m_err = 1;
          end
        end
        if (pop) void'(mbuf.pop_front());
        if (exp_req_valid && imem_req_ready) begin
          mbuf.push_back('{pc: m_fpc, instr: 32'h0, filled: 1'b0});
          m_fpc = m_fpc + 32'd4;
        end
      end
      if (rsp && !inj_v) void'(mq.pop_front());
      if (s_dut_req && imem_req_ready)
        mq.push_back('{addr: s_dut_addr, due: cyc + lat + int'($urandom_range(0, jit_max))});
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; redirect_valid = 0; redirect_pc = '0;
    imem_req_ready = 1; out_ready = 1; inj_v = 0;
    drive(); tick(); drive(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    lat = 1; jit_max = 0;
    reset = 1; redirect_valid = 0; imem_req_ready = 1; out_ready = 1;
    drive(); tick(); drive(); tick();
    drive();
    checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL rst_req_valid: got %b expected 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL rst_req_addr: got %h expected 0", imem_req_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin failures++; $display("FAIL rst_out_pc_instr: got %h/%h expected 0/0", out_pc, out_instr); end
    checks++; if (out_pcplus4 !== 32'h4) begin failures++; $display("FAIL rst_pcplus4: got %h expected 4", out_pcplus4); end
    checks++; if (dbg_count !== '0) begin failures++; $display("FAIL rst_count: got %0d expected 0", dbg_count); end
    checks++; if (err_unexpected_rsp !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", err_unexpected_rsp); end
    reset = 0;
    drive();
    checks++; if (imem_req_valid !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_release: got req=%b out=%b expected 1/0", imem_req_valid, out_valid); end
    tick();
  endtask

  task automatic test_stream();
    int k = 0;
    bit ev;
    lat = 1; jit_max = 0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive();
      ev = (i >= 2);
      checks++;
      if (out_valid !== ev) begin failures++; $display("FAIL stream_valid c%0d: got %b expected %b", i, out_valid, ev); end
      if (out_valid === 1'b1) begin
        checks++;
        if (out_pc !== 32'(4*k) || out_instr !== mem_word(32'(4*k)) || out_pcplus4 !== 32'(4*k+4)) begin
          failures++;
          $display("FAIL stream_entry %0d: got %h/%h/%h expected %h/%h/%h", k, out_pc, out_instr, out_pcplus4,
                   32'(4*k), mem_word(32'(4*k)), 32'(4*k+4));
        end
        k++;
      end
      tick();
    end
  endtask

  task automatic test_full();
    logic [31:0] acc[$];
    logic [31:0] popped[$];
    logic [31:0] resume_addr = '0;
    bit resumed = 0;
    lat = 1; jit_max = 0;
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      drive();
      if (imem_req_valid && imem_req_ready) acc.push_back(imem_req_addr);
      tick();
    end
    out_ready = 1;
    drive();
    checks++; if (acc.size() != 4) begin failures++; $display("FAIL full_nreq: got %0d expected 4", acc.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= acc.size() || acc[i] !== 32'(4*i)) begin failures++; $display("FAIL full_req_addr %0d: got %h expected %h", i, (i < acc.size()) ? acc[i] : 32'hx, 32'(4*i)); end
    end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL full_req_low: got %b expected 0", imem_req_valid); end
    checks++; if (dbg_count !== CW'(4)) begin failures++; $display("FAIL full_count: got %0d expected 4", dbg_count); end
    for (int j = 0; j < 12; j++) begin
      if (j > 0) drive();
      if (out_valid === 1'b1 && popped.size() < 4) popped.push_back(out_pc);
      if (imem_req_valid === 1'b1 && !resumed) begin resumed = 1; resume_addr = imem_req_addr; end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= popped.size() || popped[i] !== 32'(4*i)) begin failures++; $display("FAIL full_drain %0d: got %h expected %h", i, (i < popped.size()) ? popped[i] : 32'hx, 32'(4*i)); end
    end
    checks++; if (!resumed || resume_addr !== 32'h10) begin failures++; $display("FAIL full_resume: got %h (seen %0d) expected 10", resume_addr, resumed); end
  endtask

  task automatic test_redirect_inflight();
    bit seen = 0;
    int first_j = -1, stale = 0;
    logic [31:0] first_pc = '0, first_instr = '0;
    lat = 3; jit_max = 0;
    do_reset();
    for (int i = 0; i < 2; i++) begin drive(); tick(); end
    redirect_valid = 1; redirect_pc = 32'h100;
    drive();
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_no_req: got %b expected 0", imem_req_valid); end
    tick();
    redirect_valid = 0;
    drive();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin failures++; $display("FAIL redir_target_req: got %b/%h expected 1/100", imem_req_valid, imem_req_addr); end
    checks++; if (dbg_count !== '0) begin failures++; $display("FAIL redir_count: got %0d expected 0", dbg_count); end
    tick();
    for (int j = 0; j < 20; j++) begin
      drive();
      if (out_valid === 1'b1) begin
        if (!seen) begin seen = 1; first_j = j; first_pc = out_pc; first_instr = out_instr; end
        if (out_pc < 32'h100) stale++;
      end
      tick();
    end
    checks++; if (!seen || first_pc !== 32'h100 || first_instr !== mem_word(32'h100)) begin failures++; $display("FAIL redir_first: got %h/%h expected 100/%h", first_pc, first_instr, mem_word(32'h100)); end
    checks++; if (first_j != 3) begin failures++; $display("FAIL redir_first_time: got %0d expected 3", first_j); end
    checks++; if (stale != 0) begin failures++; $display("FAIL redir_stale: got %0d expected 0", stale); end
  endtask

  task automatic test_redirect_rsp_pop();
    bit seen = 0;
    logic [31:0] fpc = '0, fin = '0;
    lat = 1; jit_max = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(); tick(); end
    redirect_valid = 1; redirect_pc = 32'h203;
    drive();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rrp_pop_cycle: got %b expected 1", out_valid); end
    tick();
    redirect_valid = 0;
    drive();
    checks++; if (dbg_count !== '0) begin failures++; $display("FAIL rrp_count: got %0d expected 0", dbg_count); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin failures++; $display("FAIL rrp_req: got %b/%h expected 1/200", imem_req_valid, imem_req_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rrp_out_cleared: got %b expected 0", out_valid); end
    tick();
    for (int j = 0; j < 8; j++) begin
      drive();
      if (out_valid === 1'b1 && !seen) begin seen = 1; fpc = out_pc; fin = out_instr; end
      tick();
    end
    checks++; if (!seen || fpc !== 32'h200 || fin !== mem_word(32'h200)) begin failures++; $display("FAIL rrp_first: got %h/%h expected 200/%h", fpc, fin, mem_word(32'h200)); end
  endtask

  task automatic test_req_stall();
    logic [31:0] held = '0;
    lat = 1; jit_max = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(); tick(); end
    imem_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive();
      checks++;
      if (i == 0) begin
        held = imem_req_addr;
        if (imem_req_valid !== 1'b1 || held !== 32'h10) begin failures++; $display("FAIL stall_start: got %b/%h expected 1/10", imem_req_valid, held); end
      end else if (imem_req_valid !== 1'b1 || imem_req_addr !== held) begin
        failures++; $display("FAIL stall_hold c%0d: got %b/%h expected 1/%h", i, imem_req_valid, imem_req_addr, held);
      end
      tick();
    end
    imem_req_ready = 1;
    drive();
    checks++; if (imem_req_addr !== 32'h10 || dbg_count !== '0) begin failures++; $display("FAIL stall_release: got %h/%0d expected 10/0", imem_req_addr, dbg_count); end
    tick();
    drive();
    checks++; if (imem_req_addr !== 32'h14) begin failures++; $display("FAIL stall_advance: got %h expected 14", imem_req_addr); end
    tick();
  endtask

  task automatic test_unexpected_rsp();
    int n = 0;
    lat = 1; jit_max = 0;
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin drive(); tick(); end
    drive();
    checks++; if (err_unexpected_rsp !== 1'b0) begin failures++; $display("FAIL unexp_before: got %b expected 0", err_unexpected_rsp); end
    tick();
    inj_v = 1; inj_d = 32'hDEAD_BEEF;
    drive(); tick();
    inj_v = 0;
    drive();
    checks++; if (err_unexpected_rsp !== 1'b1) begin failures++; $display("FAIL unexp_rise: got %b expected 1", err_unexpected_rsp); end
    checks++; if (dbg_count !== CW'(4)) begin failures++; $display("FAIL unexp_count: got %0d expected 4", dbg_count); end
    out_ready = 1;
    for (int j = 0; j < 8; j++) begin
      drive();
      if (out_valid === 1'b1 && n < 4) begin
        checks++;
        if (out_pc !== 32'(4*n) || out_instr !== mem_word(32'(4*n))) begin failures++; $display("FAIL unexp_content %0d: got %h/%h expected %h/%h", n, out_pc, out_instr, 32'(4*n), mem_word(32'(4*n))); end
        n++;
      end
      checks++; if (err_unexpected_rsp !== 1'b1) begin failures++; $display("FAIL unexp_sticky c%0d: got %b expected 1", j, err_unexpected_rsp); end
      tick();
    end
    checks++; if (n != 4) begin failures++; $display("FAIL unexp_drained: got %0d expected 4", n); end
    do_reset();
    drive();
    checks++; if (err_unexpected_rsp !== 1'b0) begin failures++; $display("FAIL unexp_cleared: got %b expected 0", err_unexpected_rsp); end
    tick();
  endtask

  task automatic test_wrap();
    int n = 0;
    logic [31:0] e;
    lat = 1; jit_max = 0;
    do_reset();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFA;
    drive(); tick();
    redirect_valid = 0;
    for (int j = 0; j < 12; j++) begin
      drive();
      if (out_valid === 1'b1 && n < 4) begin
        e = 32'hFFFF_FFF8 + 32'(4*n);
        checks++;
        if (out_pc !== e || out_pcplus4 !== e + 32'd4) begin failures++; $display("FAIL wrap %0d: got %h/%h expected %h/%h", n, out_pc, out_pcplus4, e, e + 32'd4); end
        n++;
      end
      tick();
    end
    checks++; if (n != 4) begin failures++; $display("FAIL wrap_count: got %0d expected 4", n); end
  endtask

  task automatic test_random();
    lat = int'($urandom_range(1, 3)); jit_max = 2;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(0, 255) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                   : 32'($urandom_range(0, 1023));
      imem_req_ready = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      drive();
      checks++; if (imem_req_valid !== exp_req_valid) begin failures++; $display("FAIL rnd_req_valid c%0d: got %b expected %b", i, imem_req_valid, exp_req_valid); end
      if (exp_req_valid) begin
        checks++; if (imem_req_addr !== exp_req_addr) begin failures++; $display("FAIL rnd_req_addr c%0d: got %h expected %h", i, imem_req_addr, exp_req_addr); end
      end
      checks++; if (out_valid !== exp_out_valid) begin failures++; $display("FAIL rnd_out_valid c%0d: got %b expected %b", i, out_valid, exp_out_valid); end
      if (exp_out_valid) begin
        checks++;
        if (out_pc !== exp_out_pc || out_instr !== exp_out_instr || out_pcplus4 !== exp_out_pc + 32'd4) begin
          failures++; $display("FAIL rnd_out c%0d: got %h/%h/%h expected %h/%h/%h", i, out_pc, out_instr, out_pcplus4, exp_out_pc, exp_out_instr, exp_out_pc + 32'd4);
        end
      end
      checks++; if (dbg_count !== exp_count) begin failures++; $display("FAIL rnd_count c%0d: got %0d expected %0d", i, dbg_count, exp_count); end
      checks++; if (err_unexpected_rsp !== exp_err) begin failures++; $display("FAIL rnd_err c%0d: got %b expected %b", i, err_unexpected_rsp, exp_err); end
      tick();
    end
    reset = 0; redirect_valid = 0;
  endtask

  initial begin
    reset = 1; redirect_valid = 0; redirect_pc = '0;
    imem_req_ready = 1; out_ready = 1;
    imem_rsp_valid = 0; imem_rsp_data = '0;
    m_fpc = '0; m_drop = 0; m_err = 0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_full();
    test_redirect_inflight();
    test_redirect_rsp_pop();
    test_req_stall();
    test_unexpected_rsp();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
